// File: rtl/dff_bank_arbiter.sv
// rtl/dff_bank_arbiter.sv - round-robin arbiter and write sequencer for a shared DFF register
module dff_bank_arbiter #(
  parameter int WIDTH = 8,
  parameter int NREQ  = 4,
  parameter int IDX_W = 2
) (
  input  logic                  CLK,
  input  logic                  RESET,
  input  logic [NREQ-1:0]       REQ,
  input  logic [NREQ*WIDTH-1:0] WDATA,
  output logic [NREQ-1:0]       GNT,
  output logic                  DONE,
  output logic [WIDTH-1:0]      Q,
  output logic [IDX_W-1:0]      OWNER,
  output logic                  BUSY
);

  localparam int NSLOT = 2**IDX_W;

  typedef enum logic [1:0] {IDLE, GRANT, RELEASE} state_t;

  state_t            state, state_nxt;
  logic [IDX_W-1:0]  ptr, ptr_nxt, owner_nxt, ptr_after;
  logic [IDX_W-1:0]  sel, cand;
  logic              found;
  logic [NREQ-1:0]   gnt_nxt;
  logic              done_nxt;
  logic [WIDTH-1:0]  q_nxt;

  // Requests and data padded to the full index range so OWNER can index directly.
  logic [NSLOT-1:0]  req_pad;
  logic [WIDTH-1:0]  wdata_slot [NSLOT];

  always_comb begin
    req_pad = '0;
    req_pad[NREQ-1:0] = REQ;
  end

  generate
    for (genvar i = 0; i < NSLOT; i++) begin : g_slot
      if (i < NREQ) begin : g_real
        assign wdata_slot[i] = WDATA[i*WIDTH +: WIDTH];
      end else begin : g_pad
        assign wdata_slot[i] = '0;
      end
    end
  endgenerate

  // First requester at or after the round-robin pointer, wrapping modulo NREQ.
  always_comb begin
    found = 1'b0;
    sel   = '0;
    cand  = '0;
    for (int k = 0; k < NREQ; k++) begin
      cand = IDX_W'((int'(ptr) + k) % NREQ);
      if (!found && req_pad[cand]) begin
        found = 1'b1;
        sel   = cand;
      end
    end
  end

  assign ptr_after = (OWNER == IDX_W'(NREQ - 1)) ? '0 : OWNER + 1'b1;
  assign BUSY      = (state != IDLE);

  always_comb begin
    state_nxt = state;
    ptr_nxt   = ptr;
    gnt_nxt   = GNT;
    done_nxt  = 1'b0;
    q_nxt     = Q;
    owner_nxt = OWNER;
    case (state)
      IDLE: begin
        if (found) begin
          for (int i = 0; i < NREQ; i++) begin
            gnt_nxt[i] = (IDX_W'(i) == sel);
          end
          owner_nxt = sel;
          state_nxt = GRANT;
        end
      end
      GRANT: begin
        if (req_pad[OWNER]) begin
          q_nxt     = wdata_slot[OWNER];
          done_nxt  = 1'b1;
          state_nxt = RELEASE;
        end else begin
          // Owner withdrew before the write: abandon without touching Q.
          gnt_nxt   = '0;
          ptr_nxt   = ptr_after;
          state_nxt = IDLE;
        end
      end
      RELEASE: begin
        if (!req_pad[OWNER]) begin
          gnt_nxt   = '0;
          ptr_nxt   = ptr_after;
          state_nxt = IDLE;
        end
      end
      default: begin
        gnt_nxt   = '0;
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state <= IDLE;
      ptr   <= '0;
      GNT   <= '0;
      DONE  <= 1'b0;
      Q     <= '0;
      OWNER <= '0;
    end else begin
      state <= state_nxt;
      ptr   <= ptr_nxt;
      GNT   <= gnt_nxt;
      DONE  <= done_nxt;
      Q     <= q_nxt;
      OWNER <= owner_nxt;
    end
  end

endmodule

// File: tb/tb_dff_bank_arbiter.sv
// tb/tb_dff_bank_arbiter.sv - vector table plus randomized model check for dff_bank_arbiter
module tb_dff_bank_arbiter;
  localparam int WIDTH = 8;
  localparam int NREQ  = 4;
  localparam int IDX_W = 2;

  logic        CLK = 1'b0;
  logic        RESET;
  logic [3:0]  REQ;
  logic [31:0] WDATA;
  logic [3:0]  GNT;
  logic        DONE;
  logic [7:0]  Q;
  logic [1:0]  OWNER;
  logic        BUSY;

  dff_bank_arbiter #(.WIDTH(WIDTH), .NREQ(NREQ), .IDX_W(IDX_W)) dut (
    .CLK(CLK), .RESET(RESET), .REQ(REQ), .WDATA(WDATA),
    .GNT(GNT), .DONE(DONE), .Q(Q), .OWNER(OWNER), .BUSY(BUSY)
  );

  always #5 CLK = ~CLK;

  int n_checks = 0;
  int n_err    = 0;

  typedef struct {
    logic        rst;
    logic [3:0]  req;
    logic [31:0] wd;
    logic [3:0]  gnt;
    logic        done;
    logic [7:0]  q;
    logic [1:0]  own;
    logic        busy;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic rst, input logic [3:0] req, input logic [31:0] wd,
                     input logic [3:0] gnt, input logic done, input logic [7:0] q,
                     input logic [1:0] own, input logic busy);
    vec_t v;
    v.rst = rst; v.req = req; v.wd = wd; v.gnt = gnt;
    v.done = done; v.q = q; v.own = own; v.busy = busy;
    tbl.push_back(v);
  endtask

  task automatic check(input string name, input int idx, input logic [3:0] gnt,
                       input logic done, input logic [7:0] q, input logic [1:0] own,
                       input logic busy);
    n_checks++;
    if (GNT !== gnt || DONE !== done || Q !== q || OWNER !== own || BUSY !== busy) begin
      n_err++;
      $display("FAIL %s[%0d]: got gnt=%b done=%b q=%h owner=%0d busy=%b, want gnt=%b done=%b q=%h owner=%0d busy=%b",
               name, idx, GNT, DONE, Q, OWNER, BUSY, gnt, done, q, own, busy);
    end
  endtask

  // Reference model: owner index, pointer, and whether the owner's write has happened.
  int         m_ptr, m_owner;
  bit         m_busy, m_written, m_done;
  logic [7:0] m_q;

  task automatic model_reset();
    m_ptr = 0; m_owner = 0; m_busy = 0; m_written = 0; m_done = 0; m_q = 8'h00;
  endtask

  task automatic model_step(input logic [3:0] req, input logic [31:0] wd);
    bit         picked;
    logic [31:0] sh;
    m_done = 0;
    if (!m_busy) begin
      picked = 0;
      for (int k = 0; k < NREQ; k++) begin
        int i;
        i = (m_ptr + k) % NREQ;
        if (!picked && ((req >> i) & 4'd1) != 4'd0) begin
          picked = 1; m_owner = i; m_busy = 1; m_written = 0;
        end
      end
    end else if (((req >> m_owner) & 4'd1) == 4'd0) begin
      m_busy = 0;
      m_ptr  = (m_owner + 1) % NREQ;
    end else if (!m_written) begin
      sh = wd >> (8 * m_owner);
      m_q = sh[7:0];
      m_done = 1;
      m_written = 1;
    end
  endtask

  task automatic model_check(input string name, input int idx);
    logic [3:0] g;
    g = m_busy ? 4'(1 << m_owner) : 4'b0000;
    check(name, idx, g, m_done, m_q, 2'(m_owner), m_busy);
  endtask

  localparam logic [31:0] D0 = 32'h13A5_1110;
  localparam logic [31:0] D1 = 32'h1312_1110;
  localparam logic [31:0] D2 = 32'h1312_3C10;

  initial begin
    logic [3:0]  r;
    logic [31:0] d;
    logic [31:0] mask;
    bit          rst;

    RESET = 1'b1;
    REQ   = 4'($urandom);
    WDATA = $urandom;

    //  rst  req      wdata gnt      done q      own busy
    add(1, 4'b1111, D0, 4'b0000, 0, 8'h00, 0, 0);
    add(0, 4'b0000, D0, 4'b0000, 0, 8'h00, 0, 0);
    add(0, 4'b0100, D0, 4'b0100, 0, 8'h00, 2, 1);
    add(0, 4'b0100, D0, 4'b0100, 1, 8'hA5, 2, 1);
    add(0, 4'b0000, D0, 4'b0000, 0, 8'hA5, 2, 0);
    add(1, 4'b0000, D1, 4'b0000, 0, 8'h00, 0, 0);
    add(0, 4'b1111, D1, 4'b0001, 0, 8'h00, 0, 1);
    add(0, 4'b1111, D1, 4'b0001, 1, 8'h10, 0, 1);
    add(0, 4'b1110, D1, 4'b0000, 0, 8'h10, 0, 0);
    add(0, 4'b1111, D1, 4'b0010, 0, 8'h10, 1, 1);
    add(0, 4'b1111, D1, 4'b0010, 1, 8'h11, 1, 1);
    add(0, 4'b1101, D1, 4'b0000, 0, 8'h11, 1, 0);
    add(0, 4'b1111, D1, 4'b0100, 0, 8'h11, 2, 1);
    add(0, 4'b1111, D1, 4'b0100, 1, 8'h12, 2, 1);
    add(0, 4'b1011, D1, 4'b0000, 0, 8'h12, 2, 0);
    add(0, 4'b1111, D1, 4'b1000, 0, 8'h12, 3, 1);
    add(0, 4'b1111, D1, 4'b1000, 1, 8'h13, 3, 1);
    add(0, 4'b0111, D1, 4'b0000, 0, 8'h13, 3, 0);
    add(0, 4'b1111, D1, 4'b0001, 0, 8'h13, 0, 1);
    add(0, 4'b1111, D1, 4'b0001, 1, 8'h10, 0, 1);
    add(0, 4'b1110, D1, 4'b0000, 0, 8'h10, 0, 0);
    add(0, 4'b0001, D1, 4'b0001, 0, 8'h10, 0, 1);
    add(0, 4'b0000, D1, 4'b0000, 0, 8'h10, 0, 0);
    add(0, 4'b0011, D1, 4'b0010, 0, 8'h10, 1, 1);
    add(0, 4'b0011, D1, 4'b0010, 1, 8'h11, 1, 1);
    add(0, 4'b0001, D1, 4'b0000, 0, 8'h11, 1, 0);
    add(0, 4'b0001, D1, 4'b0001, 0, 8'h11, 0, 1);
    add(0, 4'b0001, D1, 4'b0001, 1, 8'h10, 0, 1);
    add(0, 4'b0000, D1, 4'b0000, 0, 8'h10, 0, 0);
    add(0, 4'b1000, D1, 4'b1000, 0, 8'h10, 3, 1);
    add(0, 4'b1000, D1, 4'b1000, 1, 8'h13, 3, 1);
    add(0, 4'b0000, D1, 4'b0000, 0, 8'h13, 3, 0);
    add(0, 4'b1001, D1, 4'b0001, 0, 8'h13, 0, 1);
    add(0, 4'b1001, D1, 4'b0001, 1, 8'h10, 0, 1);
    add(0, 4'b1000, D1, 4'b0000, 0, 8'h10, 0, 0);
    add(0, 4'b1000, D1, 4'b1000, 0, 8'h10, 3, 1);
    add(0, 4'b0000, D1, 4'b0000, 0, 8'h10, 3, 0);
    add(0, 4'b0010, D2, 4'b0010, 0, 8'h10, 1, 1);
    add(0, 4'b0010, D2, 4'b0010, 1, 8'h3C, 1, 1);
    add(0, 4'b0010, D2, 4'b0010, 0, 8'h3C, 1, 1);

    for (int n = 0; n < tbl.size(); n++) begin
      @(negedge CLK);
      RESET = tbl[n].rst;
      REQ   = tbl[n].req;
      WDATA = tbl[n].wd;
      @(posedge CLK);
      #1;
      check("vec", n, tbl[n].gnt, tbl[n].done, tbl[n].q, tbl[n].own, tbl[n].busy);
    end

    // Asynchronous reset while holding a grant in the release phase.
    @(negedge CLK);
    RESET = 1'b1;
    #1;
    check("async_rst", 0, 4'b0000, 0, 8'h00, 0, 0);
    @(posedge CLK);
    #1;
    check("async_rst", 1, 4'b0000, 0, 8'h00, 0, 0);
    @(negedge CLK);
    RESET = 1'b0;
    @(posedge CLK);
    #1;
    check("post_rst", 0, 4'b0010, 0, 8'h00, 1, 1);
    @(posedge CLK);
    #1;
    check("post_rst", 1, 4'b0010, 1, 8'h3C, 1, 1);

    // Randomized traffic against the reference model, with occasional resets.
    @(negedge CLK);
    RESET = 1'b1;
    REQ   = 4'b0000;
    @(posedge CLK);
    @(negedge CLK);
    RESET = 1'b0;
    model_reset();
    for (int c = 0; c < 3000; c++) begin
      @(negedge CLK);
      rst = ($urandom_range(0, 63) == 0);
      r = REQ;
      d = WDATA;
      for (int i = 0; i < NREQ; i++) begin
        if ($urandom_range(0, 3) == 0) begin
          if (((r >> i) & 4'd1) == 4'd0) begin
            mask = 32'h0000_00FF << (8 * i);
            d = (d & ~mask) | ((32'($urandom) & 32'h0000_00FF) << (8 * i));
          end
          r = r ^ (4'b0001 << i);
        end
      end
      REQ   = r;
      WDATA = d;
      RESET = rst;
      if (rst) begin
        #1;
        model_reset();
        model_check("rnd_async_rst", c);
      end
      @(posedge CLK);
      #1;
      if (rst) model_reset();
      else     model_step(REQ, WDATA);
      model_check("rnd", c);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
